// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: fetch-stage bundle (control in, ROM address and IF/ID register out); IF_ALIGN_CHECK_EN adds id_excp_adel
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target_address;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
`ifdef IF_ALIGN_CHECK_EN
    logic              id_excp_adel;
`endif

    // The fetch stage drives the ROM address and the IF/ID register
    modport master (
        input  stall, flush, new_pc, branch_flag, branch_target_address, inst,
        output pc, ce, id_pc, id_inst
`ifdef IF_ALIGN_CHECK_EN
        , output id_excp_adel
`endif
    );

    // The pipeline control, ROM and decode stage sit on the other side
    modport slave (
        output stall, flush, new_pc, branch_flag, branch_target_address, inst,
        input  pc, ce, id_pc, id_inst
`ifdef IF_ALIGN_CHECK_EN
        , input id_excp_adel
`endif
    );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, ROM chip-enable and IF/ID pipeline register; IF_ALIGN_CHECK_EN adds misaligned-fetch flag
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    if_fetch_stage_if.master  bus
);
    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              bubble, capture, misaligned;
    logic              unused_stall;

    assign unused_stall = ^bus.stall[5:3];
`ifdef IF_ALIGN_CHECK_EN
    logic id_excp_adel_q, id_excp_adel_d;
    assign misaligned       = pc_q[1:0] != 2'b00;
    assign bus.id_excp_adel = id_excp_adel_q;
`else
    assign misaligned = 1'b0;
`endif

    // Next PC: the first enabled cycle re-presents RESET_PC; flush beats stall beats branch
    always_comb begin
        ce_d = 1'b1;
        pc_d = !ce_q         ? pc_q :
               bus.flush     ? bus.new_pc :
               bus.stall[0]  ? pc_q :
               bus.branch_flag ? bus.branch_target_address :
               pc_q + ADDR_W'(4);
    end

    // IF/ID: flush or a stalled IF feeding a running ID inserts a bubble; both stalled holds
    always_comb begin
        bubble    = bus.flush || (bus.stall[1] && !bus.stall[2]);
        capture   = !bus.stall[1];
        id_pc_d   = bubble ? '0 : capture ? pc_q : id_pc_q;
        id_inst_d = bubble ? '0 : capture ? (misaligned ? '0 : bus.inst) : id_inst_q;
`ifdef IF_ALIGN_CHECK_EN
        id_excp_adel_d = bubble ? 1'b0 : capture ? misaligned : id_excp_adel_q;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q      <= 1'b0;
            pc_q      <= RESET_PC;
            id_pc_q   <= '0;
            id_inst_q <= '0;
`ifdef IF_ALIGN_CHECK_EN
            id_excp_adel_q <= 1'b0;
`endif
        end else begin
            ce_q      <= ce_d;
            pc_q      <= pc_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
`ifdef IF_ALIGN_CHECK_EN
            id_excp_adel_q <= id_excp_adel_d;
`endif
        end
    end

    assign bus.pc      = pc_q;
    assign bus.ce      = ce_q;
    assign bus.id_pc   = id_pc_q;
    assign bus.id_inst = id_inst_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of reset, sequencing, branch, stall, bubble, flush, wrap and async reset
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ROM word at address a is 0x1000_0000 + word index; disabled ROM reads 0
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.inst = bus.ce ? rom_word(bus.pc) : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic ce, input logic [31:0] pc,
                                input logic [31:0] id_pc, input logic [31:0] id_inst);
        check({tag, ".ce"}, {31'b0, bus.ce}, {31'b0, ce});
        check({tag, ".pc"}, bus.pc, pc);
        check({tag, ".id_pc"}, bus.id_pc, id_pc);
        check({tag, ".id_inst"}, bus.id_inst, id_inst);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall = 6'b0;
        bus.flush = 1'b0;
        bus.new_pc = 32'h0;
        bus.branch_flag = 1'b0;
        bus.branch_target_address = 32'h0;
        #1;
        expect_state("reset", 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
        check("reset.adel", {31'b0, bus.id_excp_adel}, 32'h0);
`endif
        tick(); tick(); tick();
        expect_state("in_reset", 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        expect_state("cyc0", 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        expect_state("cyc1", 1'b1, 32'h0, 32'h0, 32'h0);
        tick();
        expect_state("cyc2", 1'b1, 32'h4, 32'h0, 32'h1000_0000);
        tick();
        expect_state("cyc3", 1'b1, 32'h8, 32'h4, 32'h1000_0001);
        // Branch at 0x08 to 0x40, delay-slot word captured
        bus.branch_flag = 1'b1;
        bus.branch_target_address = 32'h40;
        tick();
        bus.branch_flag = 1'b0;
        expect_state("branch", 1'b1, 32'h40, 32'h8, 32'h1000_0002);
        tick();
        expect_state("post_br", 1'b1, 32'h44, 32'h40, 32'h1000_0010);
        // Flush to 0x0C
        bus.flush = 1'b1;
        bus.new_pc = 32'hC;
        tick();
        bus.flush = 1'b0;
        expect_state("flush", 1'b1, 32'hC, 32'h0, 32'h0);
        tick();
        expect_state("to_10", 1'b1, 32'h10, 32'hC, 32'h1000_0003);
        // Full stall for 2 cycles
        bus.stall = 6'b000111;
        tick();
        expect_state("stall1", 1'b1, 32'h10, 32'hC, 32'h1000_0003);
        tick();
        expect_state("stall2", 1'b1, 32'h10, 32'hC, 32'h1000_0003);
        bus.stall = 6'b0;
        tick();
        expect_state("unstall", 1'b1, 32'h14, 32'h10, 32'h1000_0004);
        // Bubble at 0x10
        bus.flush = 1'b1;
        bus.new_pc = 32'hC;
        tick();
        bus.flush = 1'b0;
        tick();
        expect_state("pre_bub", 1'b1, 32'h10, 32'hC, 32'h1000_0003);
        bus.stall = 6'b000011;
        tick();
        bus.stall = 6'b0;
        expect_state("bubble", 1'b1, 32'h10, 32'h0, 32'h0);
        tick();
        expect_state("post_bub", 1'b1, 32'h14, 32'h10, 32'h1000_0004);
        // Flush beats stall and branch
        bus.flush = 1'b1;
        bus.new_pc = 32'h20;
        bus.branch_flag = 1'b1;
        bus.branch_target_address = 32'h40;
        bus.stall = 6'b000111;
        tick();
        bus.flush = 1'b0;
        bus.branch_flag = 1'b0;
        bus.stall = 6'b0;
        expect_state("simul", 1'b1, 32'h20, 32'h0, 32'h0);
        tick();
        expect_state("post_sim", 1'b1, 32'h24, 32'h20, 32'h1000_0008);
        // PC wraps from 0xFFFF_FFFC to 0
        bus.flush = 1'b1;
        bus.new_pc = 32'hFFFF_FFFC;
        tick();
        bus.flush = 1'b0;
        expect_state("to_top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
        tick();
        expect_state("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        // PC stall ignores branch, IF still captures
        bus.stall = 6'b000001;
        bus.branch_flag = 1'b1;
        bus.branch_target_address = 32'h80;
        tick();
        bus.stall = 6'b0;
        bus.branch_flag = 1'b0;
        expect_state("pcstall", 1'b1, 32'h0, 32'h0, 32'h1000_0000);
        // Mid-run asynchronous reset at 0x30
        bus.flush = 1'b1;
        bus.new_pc = 32'h2C;
        tick();
        bus.flush = 1'b0;
        tick();
        expect_state("at_30", 1'b1, 32'h30, 32'h2C, 32'h1000_000B);
        #2;
        rst = 1'b0;
        #1;
        expect_state("async_rst", 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        expect_state("rst_rel", 1'b1, 32'h0, 32'h0, 32'h0);
        tick();
        expect_state("rst_run", 1'b1, 32'h4, 32'h0, 32'h1000_0000);
`ifdef IF_ALIGN_CHECK_EN
        // Misaligned fetch raises the flag and zeroes the instruction
        bus.branch_flag = 1'b1;
        bus.branch_target_address = 32'h42;
        tick();
        bus.branch_flag = 1'b0;
        check("adel_aligned", {31'b0, bus.id_excp_adel}, 32'h0);
        tick();
        expect_state("adel", 1'b1, 32'h46, 32'h42, 32'h0);
        check("adel_set", {31'b0, bus.id_excp_adel}, 32'h1);
        bus.flush = 1'b1;
        bus.new_pc = 32'h0;
        tick();
        bus.flush = 1'b0;
        check("adel_flush", {31'b0, bus.id_excp_adel}, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage pipeline: holds the program counter and drives the instruction ROM's address and chip-enable inputs.
- The ROM returns its 32-bit word combinationally in the same cycle.
- This block registers that word with its PC into the IF/ID pipeline register for the decode stage.
- Handles the pipeline stall vector, branch redirect from ID, and flush redirect from the exception logic.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC / instruction-address width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- stall  input  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID.
- flush  input  1  exception flush.
- new_pc  input  ADDR_W  flush redirect target.
- branch_flag  input  1  taken branch/jump from ID.
- branch_target_address  input  ADDR_W  branch target.
- inst  input  INST_W  word returned by the instruction ROM.
- pc  output  ADDR_W  fetch address to the ROM.
- ce  output  1  ROM chip-enable; 1 = enabled.
- id_pc  output  ADDR_W  registered PC to decode.
- id_inst  output  INST_W  registered instruction to decode.

Behaviour:
- Reset (rst=0, asynchronous, regardless of clk): ce=0, pc=RESET_PC, id_pc=0, id_inst=0. Every register returns to these values immediately on mid-run reset.
- ce sequencing:
  - First rising edge after rst deasserts: ce<=1, pc holds RESET_PC, so the first fetch is RESET_PC.
  - ce stays 1 until the next reset.
  - While ce=0 the ROM returns 0, so the IF/ID register captures zero.
- PC update each edge while ce=1, priority highest first:
  1. flush=1: pc<=new_pc (overrides stall and branch).
  2. stall[0]=1: pc holds; branch_flag is ignored this cycle (ID is stalled and re-presents it).
  3. branch_flag=1: pc<=branch_target_address.
  4. Otherwise pc<=pc+4, modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0.
- IF/ID register each edge, priority highest first:
  1. flush=1: id_pc<=0, id_inst<=0.
  2. stall[1]=1 and stall[2]=0: insert a bubble (id_pc<=0, id_inst<=0).
  3. stall[1]=0: id_pc<=pc, id_inst<=inst.
  4. Otherwise (stall[1]=1, stall[2]=1): hold.
- Latency: the instruction at address A appears on id_inst exactly one edge after pc==A with ce=1 and no stall/flush.
- Branch delay slot: the instruction fetched in the cycle branch_flag is asserted is captured normally; no squash.
- Inputs stall, flush and branch_flag are synchronous; they are sampled only at clk edges.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output port id_excp_adel (1 bit, reset 0), loaded in the same update cases as id_pc.
  - Flush and bubble load id_excp_adel<=0.
  - On a normal capture where pc[1:0]!=2'b00: id_excp_adel<=1, id_inst<=0, id_pc<=pc.
  - Otherwise id_excp_adel<=0.
- Undefined: the port is absent and pc[1:0] are not checked. The ROM indexes by word address, so low bits are don't-care.

Test Plan:
- Reset release: rst=0 for 3 cycles, then 1, no stall. Required sequence:
  - Cycle 0: ce=0, pc=0.
  - Cycle 1: ce=1, pc=0.
  - Cycles 2 and 3: pc=4, then pc=8.
  - id_pc goes 0 -> 0 -> 4, with id_inst = ROM[0] one edge after pc=0 with ce=1.
- Branch at pc=0x08: branch_flag=1 with target 0x40 -> next pc=0x40; id_pc=0x08 and id_inst=ROM[2] on the same edge; following pc=0x44.
- Full stall at pc=0x10: stall=6'b000111 for 2 cycles -> pc stays 0x10; id_pc/id_inst hold their prior values; after release pc=0x14.
- Bubble at pc=0x10: stall=6'b000011 for 1 cycle -> pc holds 0x10; id_pc=0, id_inst=0. Next cycle unstalled -> id_pc=0x10.
- Simultaneous events: flush=1, new_pc=0x20, branch_flag=1 with target 0x40, stall=6'b000111 -> pc=0x20, id_pc=0, id_inst=0.
- Mid-run reset at pc=0x30: drop rst between edges -> pc=RESET_PC, ce=0, and id_* = 0 immediately without a clock edge.
- With IF_ALIGN_CHECK_EN defined: branch to 0x42 -> next edge id_pc=0x42, id_inst=0, id_excp_adel=1. Without the macro: no such port.
